psum_drain: RTL

Output stage of the systolic array: it sits directly below the bottom row of processing elements and consumes their `sum_out` chain. It does four things:
- removes the per-column input skew;
- accumulates partial sums over multiple K-passes into a per-row accumulator bank;
- honours the array's 16-bit two-lane / 32-bit SIMD split;
- hands finished rows to the write-back path over a valid/ready interface.

---
 rtl/psum_pkg.sv | 10 +
 rtl/psum_lane_add.sv | 40 ++++
 rtl/psum_drain.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/psum_pkg.sv
// Shared types and constants for the psum_drain output stage.
package psum_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    localparam int PSUM_W = 32;
    localparam int LANE_W = 16;

    localparam logic SIMD_16X2 = 1'b0;
    localparam logic SIMD_32   = 1'b1;
endpackage

// File: rtl/psum_lane_add.sv
// Per-column psum adder: two independent 16-bit lanes or one 32-bit lane.
// Defining PSUM_DRAIN_SAT_EN turns every add into a signed saturating add.
module psum_lane_add
    import psum_pkg::*;
(
    input  logic [PSUM_W-1:0] a,
    input  logic [PSUM_W-1:0] b,
    input  logic              simd_mode,
    output logic [PSUM_W-1:0] sum
);
    logic [LANE_W-1:0] lo;
    logic [LANE_W-1:0] hi;
    logic [PSUM_W-1:0] wide;

    assign lo   = a[LANE_W-1:0] + b[LANE_W-1:0];
    assign hi   = a[PSUM_W-1:LANE_W] + b[PSUM_W-1:LANE_W];
    assign wide = a + b;

`ifdef PSUM_DRAIN_SAT_EN
    logic              ov_lo;
    logic              ov_hi;
    logic              ov_wide;
    logic [LANE_W-1:0] lo_sat;
    logic [LANE_W-1:0] hi_sat;
    logic [PSUM_W-1:0] wide_sat;

    // Overflow only when both operands share a sign that the result lost; clamp toward that sign.
    assign ov_lo   = (a[LANE_W-1] == b[LANE_W-1]) && (lo[LANE_W-1] != a[LANE_W-1]);
    assign ov_hi   = (a[PSUM_W-1] == b[PSUM_W-1]) && (hi[LANE_W-1] != a[PSUM_W-1]);
    assign ov_wide = (a[PSUM_W-1] == b[PSUM_W-1]) && (wide[PSUM_W-1] != a[PSUM_W-1]);

    assign lo_sat   = ov_lo   ? {a[LANE_W-1], {(LANE_W-1){~a[LANE_W-1]}}} : lo;
    assign hi_sat   = ov_hi   ? {a[PSUM_W-1], {(LANE_W-1){~a[PSUM_W-1]}}} : hi;
    assign wide_sat = ov_wide ? {a[PSUM_W-1], {(PSUM_W-1){~a[PSUM_W-1]}}} : wide;

    assign sum = (simd_mode == SIMD_32) ? wide_sat : {hi_sat, lo_sat};
`else
    assign sum = (simd_mode == SIMD_32) ? wide : {hi, lo};
`endif
endmodule

// File: rtl/psum_drain.sv
// psum_drain: de-skews the bottom PE row, accumulates K-passes per output row and
// queues finished rows for write-back. PSUM_DRAIN_SAT_EN selects saturating adds.
module psum_drain
    import psum_pkg::*;
#(
    parameter int NCOL   = 4,
    parameter int ROWS   = 16,
    parameter int PASS_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PASS_W-1:0]        cfg_passes,
    input  logic                     simd_mode,
    input  logic                     sum_in_valid,
    input  logic [NCOL*PSUM_W-1:0]   sum_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NCOL*PSUM_W-1:0]   out_data,
    output logic [$clog2(ROWS)-1:0]  out_row,
    output logic                     busy,
    output logic                     overflow
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int DW    = NCOL * PSUM_W;

    state_t            state;
    logic [PASS_W-1:0] passes;
    logic [PASS_W-1:0] pass_cnt;
    logic              simd;
    logic [ROW_W-1:0]  row_cnt;
    logic [NCOL-2:0]   valid_pipe;
    logic [DW-1:0]     beat_data;
    logic [DW-1:0]     acc_in;
    logic [DW-1:0]     lane_sum;
    logic [DW-1:0]     acc [ROWS];

    logic [DW-1:0]     fifo_data [2];
    logic [ROW_W-1:0]  fifo_row [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;
    logic [1:0]        fifo_cnt_next;

    logic accept_start, beat, last_pass, last_row, push, pop, do_push, drop;

    assign accept_start = (state == IDLE) && start;
    assign beat         = valid_pipe[NCOL-2];
    assign last_pass    = (pass_cnt == passes - PASS_W'(1));
    assign last_row     = (row_cnt == ROW_W'(ROWS - 1));
    assign push         = beat && (state == ACCUM) && last_pass;
    assign pop          = out_valid && out_ready;
    assign do_push      = push && ((fifo_cnt != 2'd2) || pop);
    assign drop         = push && !do_push;

    // Column c lags column 0 by c cycles, so it needs NCOL-1-c more stages to line up.
    for (genvar c = 0; c < NCOL; c++) begin : g_skew
        localparam int DEPTH = NCOL - 1 - c;
        if (DEPTH == 0) begin : g_direct
            assign beat_data[c*PSUM_W +: PSUM_W] = sum_in[c*PSUM_W +: PSUM_W];
        end else begin : g_delay
            logic [PSUM_W-1:0] pipe [DEPTH];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= sum_in[c*PSUM_W +: PSUM_W];
                    for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign beat_data[c*PSUM_W +: PSUM_W] = pipe[DEPTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || accept_start) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= sum_in_valid;
            for (int i = 1; i < NCOL - 1; i++) valid_pipe[i] <= valid_pipe[i-1];
        end
    end

    // Pass 0 adds against zero so a single adder path covers load, accumulate and final.
    assign acc_in = (pass_cnt == '0) ? '0 : acc[row_cnt];

    for (genvar c = 0; c < NCOL; c++) begin : g_add
        psum_lane_add u_add (
            .a         (acc_in[c*PSUM_W +: PSUM_W]),
            .b         (beat_data[c*PSUM_W +: PSUM_W]),
            .simd_mode (simd),
            .sum       (lane_sum[c*PSUM_W +: PSUM_W])
        );
    end

    always_comb begin
        fifo_cnt_next = fifo_cnt;
        if (do_push && !pop)      fifo_cnt_next = fifo_cnt + 2'd1;
        else if (pop && !do_push) fifo_cnt_next = fifo_cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
            passes   <= '0;
            pass_cnt <= '0;
            row_cnt  <= '0;
            simd     <= 1'b0;
            for (int r = 0; r < ROWS; r++) acc[r] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        pass_cnt <= '0;
                        row_cnt  <= '0;
                        passes   <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
                        simd     <= simd_mode;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        if (last_row) begin
                            row_cnt  <= '0;
                            pass_cnt <= pass_cnt + PASS_W'(1);
                            if (last_pass) state <= DRAIN;
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                        if (!last_pass) acc[row_cnt] <= lane_sum;
                    end
                end
                DRAIN: begin
                    if (fifo_cnt_next == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_row[i]  <= '0;
            end
        end else begin
            if (do_push) begin
                fifo_data[wr_ptr] <= lane_sum;
                fifo_row[wr_ptr]  <= row_cnt;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt_next;
        end
    end

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_row   = fifo_row[rd_ptr];
endmodule
